// File: rtl/mm_port_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters access to one memory port,
// with lock-based grant holding and a fixed two-edge pipelined read path.
module mm_port_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MM_DEPTH = 17,
    parameter int MM_SIZE  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ*MM_DEPTH-1:0] req_addr,
    input  logic [NUM_REQ*MM_SIZE-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [MM_SIZE-1:0]          rsp_data,
    output logic                        write_enable,
    output logic [MM_DEPTH-1:0]         write_addr,
    output logic [MM_SIZE-1:0]          write_data,
    output logic [MM_DEPTH-1:0]         read_addr,
    input  logic [MM_SIZE-1:0]          read_data,
    input  logic                        busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t              state_q;
    logic [IW-1:0]       owner_q, rr_ptr_q;
    logic                hs;
    logic [IW-1:0]       gidx, cand;
    logic                g_wr, g_lk;
    logic [MM_DEPTH-1:0] g_addr;
    logic [MM_SIZE-1:0]  g_wdata;

    logic                we_q, we_d;
    logic [MM_DEPTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [MM_SIZE-1:0]  wdata_q, wdata_d, rdata_q;
    logic                p0_vld_q, p1_vld_q;
    logic [IW-1:0]       p0_id_q, p1_id_q;
    logic [NUM_REQ-1:0]  rsp_vld_q;

    // Grant selection is purely combinational so req_ready reacts to reset/busy at once.
    always_comb begin
        hs   = 1'b0;
        gidx = '0;
        cand = '0;
        if (reset && !busy) begin
            if (state_q == LOCKED) begin
                if (req_valid[owner_q]) begin
                    hs   = 1'b1;
                    gidx = owner_q;
                end
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    cand = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
                    if (!hs && req_valid[cand]) begin
                        hs   = 1'b1;
                        gidx = cand;
                    end
                end
            end
        end
        req_ready = hs ? (NUM_REQ'(1) << gidx) : '0;
    end

    always_comb begin
        g_wr    = req_write[gidx];
        g_lk    = req_lock[gidx];
        g_addr  = req_addr[gidx*MM_DEPTH +: MM_DEPTH];
        g_wdata = req_wdata[gidx*MM_SIZE +: MM_SIZE];
        we_d    = hs && g_wr;
        waddr_d = we_d ? g_addr : '0;
        wdata_d = we_d ? g_wdata : '0;
        raddr_d = (hs && !g_wr) ? g_addr : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else if (hs) begin
            if (state_q == ARB) begin
                rr_ptr_q <= IW'((int'(gidx) + 1) % NUM_REQ);
                if (g_lk) begin
                    state_q <= LOCKED;
                    owner_q <= gidx;
                end
            end else if (!g_lk) begin
                state_q  <= ARB;
                rr_ptr_q <= IW'((int'(owner_q) + 1) % NUM_REQ);
            end
        end
    end

    // p0/p1 carry the requester id alongside read_data's one-cycle memory latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            raddr_q   <= '0;
            p0_vld_q  <= 1'b0;
            p0_id_q   <= '0;
            p1_vld_q  <= 1'b0;
            p1_id_q   <= '0;
            rsp_vld_q <= '0;
            rdata_q   <= '0;
        end else begin
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            raddr_q   <= raddr_d;
            p0_vld_q  <= hs && !g_wr;
            p0_id_q   <= (hs && !g_wr) ? gidx : '0;
            p1_vld_q  <= p0_vld_q;
            p1_id_q   <= p0_id_q;
            rsp_vld_q <= p1_vld_q ? (NUM_REQ'(1) << p1_id_q) : '0;
            if (p1_vld_q) rdata_q <= read_data;
        end
    end

    assign write_enable = we_q;
    assign write_addr   = waddr_q;
    assign write_data   = wdata_q;
    assign read_addr    = raddr_q;
    assign rsp_valid    = rsp_vld_q;
    assign rsp_data     = rdata_q;
endmodule

// File: tb/tb_mm_port_arbiter.sv
// Scoreboard bench for mm_port_arbiter: directed scenarios plus random traffic
// checked against a transaction-level arbitration model.
module tb_mm_port_arbiter;
    localparam int N  = 4;
    localparam int MD = 17;
    localparam int MS = 16;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0]    req_valid, req_write, req_lock, req_ready, rsp_valid;
    logic [N*MD-1:0] req_addr;
    logic [N*MS-1:0] req_wdata;
    logic [MS-1:0]   rsp_data, write_data, read_data;
    logic [MD-1:0]   write_addr, read_addr;
    logic            write_enable, busy;

    mm_port_arbiter #(.NUM_REQ(N), .MM_DEPTH(MD), .MM_SIZE(MS)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .read_addr(read_addr), .read_data(read_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [MS-1:0] mem_fn(input logic [MD-1:0] a);
        logic [31:0] t;
        t = (32'(a) << 9) ^ (32'(a) >> 8);
        return t[MS-1:0];
    endfunction

    // Memory returns data for read_addr one cycle later.
    always @(posedge clk) read_data <= mem_fn(read_addr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        int            due;
        logic [MS-1:0] data;
        logic [MD-1:0] addr;
        int            id;
    } ev_t;
    ev_t wq[$], rq[$], raq[$];

    // Reference model state
    int rr = 0;
    bit locked = 0;
    int owner = 0;

    logic [N-1:0]  va, wr, lk;
    logic          bz;
    logic [MD-1:0] ad[N];
    logic [MS-1:0] wd[N];

    function automatic int model_grant();
        if (!reset || bz) return -1;
        if (locked) return va[owner] ? owner : -1;
        for (int k = 0; k < N; k++) if (va[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    task automatic model_update(input int g);
        if (!locked) begin
            rr = (g + 1) % N;
            if (lk[g]) begin
                locked = 1;
                owner  = g;
            end
        end else if (!lk[g]) begin
            locked = 0;
            rr     = (owner + 1) % N;
        end
    endtask

    task automatic step(output int g);
        @(negedge clk);
        req_valid = va; req_write = wr; req_lock = lk; busy = bz;
        for (int i = 0; i < N; i++) begin
            req_addr[i*MD +: MD]  = ad[i];
            req_wdata[i*MS +: MS] = wd[i];
        end
        #1;
        g = model_grant();
        chk("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        if (g >= 0) begin
            if (wr[g]) wq.push_back('{cyc + 1, wd[g], ad[g], g});
            else begin
                raq.push_back('{cyc + 1, '0, ad[g], g});
                rq.push_back('{cyc + 3, mem_fn(ad[g]), ad[g], g});
            end
            model_update(g);
        end
    endtask

    task automatic idle(input int n);
        int g;
        va = '0;
        for (int i = 0; i < n; i++) step(g);
    endtask

    task automatic assert_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_we", write_enable, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_read_addr", read_addr, 0);
        chk("rst_write_addr", write_addr, 0);
        chk("rst_write_data", write_data, 0);
        wq.delete(); rq.delete(); raq.delete();
        locked = 0; rr = 0; owner = 0;
    endtask

    // Monitor: registered outputs are compared against due scoreboard entries.
    always @(negedge clk) begin
        if (reset) begin
            if (wq.size() > 0 && wq[0].due == cyc) begin
                chk("write_enable", write_enable, 1);
                chk("write_addr", write_addr, wq[0].addr);
                chk("write_data", write_data, wq[0].data);
                void'(wq.pop_front());
            end else begin
                chk("write_idle", {write_enable, write_addr, write_data}, 0);
            end
            if (raq.size() > 0 && raq[0].due == cyc) begin
                chk("read_addr", read_addr, raq[0].addr);
                void'(raq.pop_front());
            end else begin
                chk("read_addr_idle", read_addr, 0);
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                chk("rsp_valid", rsp_valid, 64'd1 << rq[0].id);
                chk("rsp_data", rsp_data, rq[0].data);
                void'(rq.pop_front());
            end else begin
                chk("rsp_valid_idle", rsp_valid, 0);
            end
        end
    end

    initial begin
        int g, e;
        reset = 1'b0; busy = 1'b0;
        req_valid = '0; req_write = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        va = '0; wr = '0; lk = '0; bz = 1'b0;
        for (int i = 0; i < N; i++) begin ad[i] = '0; wd[i] = '0; end
        #1;
        chk("init_ready", req_ready, 0);
        chk("init_outs", {rsp_valid, write_enable, rsp_data, read_addr, write_addr, write_data}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // All requesters writing: strict rotation 0..3
        va = '1; wr = '1; lk = '0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) begin
                ad[i] = MD'(17'h100 * (i + 1) + k);
                wd[i] = MS'(16'hA000 + 16 * i + k);
            end
            step(g);
            chk("rot_grant", req_ready, 64'd1 << (k % N));
        end
        idle(2);

        // Single read by requester 2, then three back-to-back reads
        va = 4'b0100; wr = '0; ad[2] = 17'h00001;
        step(g);
        va = '0;
        for (int i = 0; i < 3; i++) step(g);
        chk("rd_rsp_valid", rsp_valid, 4'b0100);
        chk("rd_rsp_data", rsp_data, 16'h0200);
        va = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            ad[2] = MD'(k);
            step(g);
        end
        idle(4);

        // Lock: requester 1 holds the port across three writes
        va = 4'b0001; wr = '1; ad[0] = 17'h00111; wd[0] = 16'h1111;
        step(g);
        va = 4'b0011;
        ad[1] = 17'h04002; wd[1] = 16'hB002; lk = 4'b0010;
        step(g); chk("lock_w1", req_ready, 4'b0010);
        ad[1] = 17'h04003; wd[1] = 16'hB003;
        step(g); chk("lock_w2", req_ready, 4'b0010);
        va = 4'b0001;
        step(g); chk("lock_block", req_ready, 4'b0000);
        va = 4'b0011; ad[1] = 17'h04004; wd[1] = 16'hB004; lk = 4'b0000;
        step(g); chk("lock_w3", req_ready, 4'b0010);
        va = 4'b0001;
        step(g); chk("lock_release", req_ready, 4'b0001);
        idle(2);

        // Busy holds off all grants
        va = '1; wr = '1; bz = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(g);
            chk("busy_ready", req_ready, 0);
        end
        bz = 1'b0; e = rr;
        step(g);
        chk("busy_release", req_ready, 64'd1 << e);
        idle(3);

        // Reset while a read is in flight
        va = 4'b0100; wr = '0; ad[2] = 17'h00005;
        step(g);
        @(negedge clk);
        assert_reset();
        va = '1; wr = '1;
        step(g);
        va = '0;
        step(g);
        @(negedge clk);
        reset = 1'b1;
        idle(5);
        va = '1; wr = '1;
        step(g);
        chk("post_rst_grant", req_ready, 4'b0001);
        idle(2);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            va = N'($urandom); wr = N'($urandom); lk = N'($urandom & $urandom);
            bz = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < N; i++) begin
                ad[i] = MD'($urandom);
                wd[i] = MS'($urandom);
            end
            step(g);
        end
        bz = 1'b0; lk = '0;
        idle(6);
        chk("sb_empty", wq.size() + rq.size() + raq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mm_port_arbiter.md
MM_PORT_ARBITER -- requirements
Module: mm_port_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_REQ, 4, number of requesters (2..8)
- MM_DEPTH, 17, address width
- MM_SIZE, 16, data width
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- reset, in, 1, asynchronous, active-low
- req_valid, in, NUM_REQ, request pending per requester
- req_write, in, NUM_REQ, 1=write, 0=read
- req_lock, in, NUM_REQ, hold grant after this transaction
- req_addr, in, NUM_REQ*MM_DEPTH, packed addresses, requester i at slice i
- req_wdata, in, NUM_REQ*MM_SIZE, packed write data
- req_ready, out, NUM_REQ, one-hot accept
- rsp_valid, out, NUM_REQ, one-hot read-response pulse
- rsp_data, out, MM_SIZE, read response data
- write_enable, out, 1, NeuralNetwork write strobe
- write_addr, out, MM_DEPTH, NeuralNetwork write address
- write_data, out, MM_SIZE, NeuralNetwork write data
- read_addr, out, MM_DEPTH, NeuralNetwork read address
- read_data, in, MM_SIZE, NeuralNetwork read data, valid one cycle after read_addr
- busy, in, 1, NeuralNetwork busy; no transaction issued while high

Function
REQ-003 Handshake completes on the rising edge where req_valid[i]=1 and req_ready[i]=1; at most one transaction per cycle.
REQ-004 req_ready SHALL be combinational, at most one-hot, and all-zero whenever busy=1 or reset is asserted.
REQ-005 Grant in state ARB: the first requester with req_valid=1, searching from rr_ptr upward modulo NUM_REQ (wraps NUM_REQ-1 -> 0).
REQ-006 After each handshake in state ARB by requester g, rr_ptr SHALL become (g+1) mod NUM_REQ.
REQ-007 FSM states SHALL be ARB and LOCKED(owner). ARB -> LOCKED on a handshake with req_lock=1, with owner set to the granted requester.
REQ-008 LOCKED -> ARB on an owner handshake with req_lock=0; rr_ptr SHALL become (owner+1) mod NUM_REQ.
REQ-009 In LOCKED, only the owner may receive req_ready; other requesters SHALL be blocked even when the owner has req_valid=0.
REQ-010 Write handshake at edge E: write_enable=1, write_addr and write_data registered from the requester slice for the cycle after E only; otherwise write_enable=0.
REQ-011 Read handshake at edge E: read_addr registered for the cycle after E.
REQ-012 For that read, rsp_data SHALL capture read_data at edge E+2, and rsp_valid[g]=1 SHALL be asserted for exactly one cycle after E+2.
REQ-013 Read latency SHALL be fixed at 2 edges; back-to-back reads SHALL be pipelined, giving one response per cycle with ids tracked in a 2-deep (valid,id) pipe.
REQ-014 When idle, read_addr, write_addr and write_data SHALL be driven to 0, never X.
REQ-015 A busy rise does not cancel transactions already accepted; output and response pipes SHALL drain normally.
REQ-016 When a read and a write request in the same cycle, only the granted one is issued; the other waits and is not dropped.

Reset
REQ-017 On reset=0, immediately and asynchronously:
- req_ready, rsp_valid, write_enable = 0
- rsp_data, read_addr, write_addr, write_data = 0
- rr_ptr = 0, FSM = ARB, response pipe cleared
REQ-018 Reads in flight when reset asserts SHALL produce no rsp_valid after reset releases.
REQ-019 The first grant after reset release SHALL follow REQ-005 with rr_ptr=0.

Verification
REQ-020 Stimulus: all 4 requesters valid with writes, busy=0, for 8 cycles. Required: grants 0,1,2,3,0,1,2,3; write_addr follows the matching slices one cycle later.
REQ-021 Stimulus: requester 2 reads addr 0x00001, NeuralNetwork returns 0x0200. Required: rsp_valid=4'b0100 and rsp_data=16'h0200 two edges after the handshake; back-to-back reads of 0x0,0x1,0x2 give 3 consecutive responses.
REQ-022 Stimulus: requester 1 issues 3 writes (0x4002..0x4004) with lock=1,1,0 while requester 0 is also valid. Required: requester 0 is blocked until the third write, then granted next.
REQ-023 Stimulus: busy=1 for 5 cycles with all requesters valid. Required: req_ready=0 and write_enable=0 throughout; the grant after busy falls starts at rr_ptr.
REQ-024 Stimulus: reset=0 asserted one cycle after a read handshake. Required: all outputs 0 at once; no rsp_valid after release; first grant goes to requester 0.
